if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, issues fetch requests to instruction memory over a ready-based handshake, and produces `PCp4_IF`, `inst_IF` and `flush_IF` for the IF/ID pipeline register directly downstream. It handles four cases:
- hazard-unit stalls via `PCWrite`;
- branch/jump redirects coming back from ID;
- multi-cycle memory latency, by inserting NOP bubbles;
- wrong-path fetches still outstanding at redirect time, which it discards.

---
 rtl/if_fetch_stage.sv | 137 +++++++++++++
 tb/tb_if_fetch_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory over a
// req/ready handshake and feeds PC+4, the instruction and the flush request to
// the IF/ID register. Covers hazard stalls, ID redirects, memory wait states
// and squashing of wrong-path fetches still outstanding at redirect time.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCp4_IF,
  output logic [31:0] inst_IF,
  output logic        fetch_valid,
  output logic        flush_IF
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Redirect decode: jump wins over branch, targets are forced word-aligned.
  always_comb begin
    redirect = jump | branch_taken;
    target   = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
    pc_plus4 = pc_q + 32'd4;
  end

  // Next-state and output logic; reset forces the handshake and outputs idle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    inst_buf_d    = inst_buf_q;
    imem_req      = 1'b0;
    inst_IF       = NOP_INST;
    fetch_valid   = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          // The fetch in flight is on the wrong path: drop it now or later.
          if (imem_ready) begin
            pc_d = target;
          end else begin
            redirect_pc_d = target;
            state_d       = DISCARD;
          end
        end else if (imem_ready) begin
          inst_IF     = imem_rdata;
          fetch_valid = 1'b1;
          if (PCWrite) begin
            pc_d = pc_plus4;
          end else begin
            // Stalled: keep the word so it can be re-presented without refetch.
            inst_buf_d = imem_rdata;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        inst_IF     = inst_buf_q;
        fetch_valid = 1'b1;
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (PCWrite) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        // Keep the abandoned request alive until memory completes it.
        imem_req = 1'b1;
        if (redirect) begin
          redirect_pc_d = target;
        end
        if (imem_ready) begin
          pc_d    = redirect ? target : redirect_pc_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (!rst_n) begin
      imem_req    = 1'b0;
      inst_IF     = NOP_INST;
      fetch_valid = 1'b0;
    end
  end

  // Output wiring: address and PC+4 always track the PC register.
  always_comb begin
    imem_addr = pc_q;
    PCp4_IF   = pc_plus4;
    flush_IF  = redirect & rst_n;
  end

  // State and PC registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0000_0000;
      inst_buf_q    <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      inst_buf_q    <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed per-cycle vectors push their
// expected outputs, a monitor on the falling edge pops and compares them.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0400;
  localparam logic [31:0] NOP    = 32'hFFFF_0000;

  logic        clk;
  logic        rst_n;
  logic        PCWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PCp4_IF;
  logic [31:0] inst_IF;
  logic        fetch_valid;
  logic        flush_IF;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pcp4;
    logic [31:0] inst;
    logic        valid;
    logic        flush;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;

  if_fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INST (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCWrite       (PCWrite),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .PCp4_IF       (PCp4_IF),
    .inst_IF       (inst_IF),
    .fetch_valid   (fetch_valid),
    .flush_IF      (flush_IF)
  );

  // Memory content: each word tags its own address so results are traceable.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs just after the rising edge and queue expectations.
  task automatic step(input logic rn, input logic pw, input logic br,
                      input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                      input logic rdy, input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_pcp4, input logic [31:0] e_inst,
                      input logic e_valid, input logic e_flush);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = rn;
    PCWrite       = pw;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    imem_ready    = rdy;
    e.req   = e_req;
    e.addr  = e_addr;
    e.pcp4  = e_pcp4;
    e.inst  = e_inst;
    e.valid = e_valid;
    e.flush = e_flush;
    exp_q.push_back(e);
  endtask

  // Monitor: every falling edge with a pending expectation is one vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic bad;
      e   = exp_q.pop_front();
      bad = 1'b0;
      n_vec++;
      if (imem_req !== e.req) begin
        $display("FAIL v%0d imem_req: got %0b want %0b", n_vec, imem_req, e.req);
        bad = 1'b1;
      end
      if (imem_addr !== e.addr) begin
        $display("FAIL v%0d imem_addr: got %h want %h", n_vec, imem_addr, e.addr);
        bad = 1'b1;
      end
      if (PCp4_IF !== e.pcp4) begin
        $display("FAIL v%0d PCp4_IF: got %h want %h", n_vec, PCp4_IF, e.pcp4);
        bad = 1'b1;
      end
      if (inst_IF !== e.inst) begin
        $display("FAIL v%0d inst_IF: got %h want %h", n_vec, inst_IF, e.inst);
        bad = 1'b1;
      end
      if (fetch_valid !== e.valid) begin
        $display("FAIL v%0d fetch_valid: got %0b want %0b", n_vec, fetch_valid, e.valid);
        bad = 1'b1;
      end
      if (flush_IF !== e.flush) begin
        $display("FAIL v%0d flush_IF: got %0b want %0b", n_vec, flush_IF, e.flush);
        bad = 1'b1;
      end
      if (bad) n_bad++;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    PCWrite = 1'b1;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    jump = 1'b0;
    jump_target = 32'h0;
    imem_ready = 1'b1;

    //     rn pw br bt            jp jt            rdy  req addr          pcp4          inst          vld fl
    // reset: outputs idle, flush masked even with a branch pending
    step(0, 1, 1, 32'h0000_0900, 0, 32'h0,        1,   0, 32'h0000_0400, 32'h0000_0404, NOP,          0, 0);
    // zero-wait streaming
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0400, 32'h0000_0404, 32'hC0DE_0400, 1, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0404, 32'h0000_0408, 32'hC0DE_0404, 1, 0);
    // stall while 0x408 returns: held for three cycles, no request in HOLD
    step(1, 0, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0408, 32'h0000_040C, 32'hC0DE_0408, 1, 0);
    step(1, 0, 0, 32'h0,         0, 32'h0,        1,   0, 32'h0000_0408, 32'h0000_040C, 32'hC0DE_0408, 1, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   0, 32'h0000_0408, 32'h0000_040C, 32'hC0DE_0408, 1, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_040C, 32'h0000_0410, 32'hC0DE_040C, 1, 0);
    // taken branch, then jump beats branch (low target bits cleared)
    step(1, 1, 1, 32'h0000_0500, 0, 32'h0,        1,   1, 32'h0000_0410, 32'h0000_0414, NOP,          0, 1);
    step(1, 1, 1, 32'h0000_0500, 1, 32'h0000_0603, 1,  1, 32'h0000_0500, 32'h0000_0504, NOP,          0, 1);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0600, 32'h0000_0604, 32'hC0DE_0600, 1, 0);
    // three wait cycles with redirect in the first one
    step(1, 1, 1, 32'h0000_0700, 0, 32'h0,        0,   1, 32'h0000_0604, 32'h0000_0608, NOP,          0, 1);
    step(1, 1, 0, 32'h0,         0, 32'h0,        0,   1, 32'h0000_0604, 32'h0000_0608, NOP,          0, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        0,   1, 32'h0000_0604, 32'h0000_0608, NOP,          0, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0604, 32'h0000_0608, NOP,          0, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0700, 32'h0000_0704, 32'hC0DE_0700, 1, 0);
    // one wait cycle gives one bubble
    step(1, 1, 0, 32'h0,         0, 32'h0,        0,   1, 32'h0000_0704, 32'h0000_0708, NOP,          0, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0704, 32'h0000_0708, 32'hC0DE_0704, 1, 0);
    // jump to the top word, PC+4 wraps to zero
    step(1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 1,  1, 32'h0000_0708, 32'h0000_070C, NOP,          0, 1);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hC0DE_FFFC, 1, 0);
    // DISCARD: a later redirect overwrites the first
    step(1, 1, 0, 32'h0,         1, 32'h0000_0800, 0,  1, 32'h0000_0000, 32'h0000_0004, NOP,          0, 1);
    step(1, 1, 1, 32'h0000_0900, 0, 32'h0,        0,   1, 32'h0000_0000, 32'h0000_0004, NOP,          0, 1);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0000, 32'h0000_0004, NOP,          0, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0900, 32'h0000_0904, 32'hC0DE_0900, 1, 0);
    // enter DISCARD, then reset there
    step(1, 1, 1, 32'h0000_0A00, 0, 32'h0,        0,   1, 32'h0000_0904, 32'h0000_0908, NOP,          0, 1);
    step(0, 1, 1, 32'h0000_0A00, 0, 32'h0,        0,   0, 32'h0000_0400, 32'h0000_0404, NOP,          0, 0);
    step(0, 1, 0, 32'h0,         0, 32'h0,        1,   0, 32'h0000_0400, 32'h0000_0404, NOP,          0, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0400, 32'h0000_0404, 32'hC0DE_0400, 1, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0404, 32'h0000_0408, 32'hC0DE_0404, 1, 0);
    // DISCARD ending with a redirect in the same cycle as ready
    step(1, 1, 1, 32'h0000_0B00, 0, 32'h0,        0,   1, 32'h0000_0408, 32'h0000_040C, NOP,          0, 1);
    step(1, 1, 0, 32'h0,         1, 32'h0000_0C00, 1,  1, 32'h0000_0408, 32'h0000_040C, NOP,          0, 1);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0C00, 32'h0000_0C04, 32'hC0DE_0C00, 1, 0);
    // redirect out of HOLD
    step(1, 0, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0C04, 32'h0000_0C08, 32'hC0DE_0C04, 1, 0);
    step(1, 0, 1, 32'h0000_0D00, 0, 32'h0,        1,   0, 32'h0000_0C04, 32'h0000_0C08, 32'hC0DE_0C04, 1, 1);
    step(1, 1, 0, 32'h0,         0, 32'h0,        1,   1, 32'h0000_0D00, 32'h0000_0D04, 32'hC0DE_0D00, 1, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
